// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD port: FSM state encoding, HD44780 command bytes
// and the power-on init sequence used when LCD_INIT_EN is defined.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
`ifdef LCD_INIT_EN
    , ST_INIT
`endif
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME      = 8'h02;
  localparam logic [7:0] LCD_CMD_FUNC_8BIT = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY     = 8'h06;

  localparam int INIT_ROM_LEN = 4;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNC_8BIT;
      2'd1:    return LCD_CMD_DISP_ON;
      2'd2:    return LCD_CMD_CLEAR;
      default: return LCD_CMD_ENTRY;
    endcase
  endfunction

  // Clear and home are the only commands that need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_if.sv
// Byte-push handshake between the MMIO write decoder (master) and lcd_driver (slave).
interface lcd_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_fifo.sv
// Small synchronous FIFO holding {rs, data} entries; no fall-through, so a byte
// pushed into an empty queue becomes visible the cycle after the push.
module lcd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_driver.sv
// Replays queued command/data bytes onto an HD44780-style bus with hardware
// setup/strobe/hold/execution timing. Optional power-on init: LCD_INIT_EN.
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH        = 4,
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 4,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 80000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lcd_if.slave                        wr,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  lcd_data,
  output logic                        lcd_rs,
  output logic                        lcd_rw,
  output logic                        lcd_e
);

  localparam int T_MAX = max_int(max_int(max_int(SETUP_CYCLES, PULSE_CYCLES),
                                         max_int(HOLD_CYCLES, CMD_WAIT_CYCLES)),
                                 CLEAR_WAIT_CYCLES);
  localparam int TW = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] CMD_LOAD   = TW'(CMD_WAIT_CYCLES - 1);
  localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_WAIT_CYCLES - 1);

  lcd_state_t  state;
  logic [TW-1:0] timer;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_pop;
  logic [8:0]    fifo_rd;

`ifdef LCD_INIT_EN
  logic [2:0]    init_idx;
`endif

  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign wr.wr_ready = !fifo_full;
  assign busy        = !fifo_empty || (state != ST_IDLE);
  assign lcd_rw      = 1'b0;

  lcd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr.wr_valid),
    .pop     (fifo_pop),
    .wr_data ({wr.wr_rs, wr.wr_data}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Each phase loads the timer with its length minus one and advances when it hits zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
`ifdef LCD_INIT_EN
      state    <= ST_INIT;
      timer    <= CLEAR_LOAD;
      init_idx <= '0;
`else
      state    <= ST_IDLE;
      timer    <= '0;
`endif
    end else begin
      case (state)
`ifdef LCD_INIT_EN
        ST_INIT: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            lcd_rs   <= 1'b0;
            lcd_data <= init_rom(init_idx[1:0]);
            init_idx <= init_idx + 3'd1;
            timer    <= SETUP_LOAD;
            state    <= ST_SETUP;
          end
        end
`endif
        ST_IDLE: begin
          if (!fifo_empty) begin
            lcd_rs   <= fifo_rd[8];
            lcd_data <= fifo_rd[7:0];
            timer    <= SETUP_LOAD;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            lcd_e <= 1'b1;
            timer <= PULSE_LOAD;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            lcd_e <= 1'b0;
            timer <= HOLD_LOAD;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            timer <= is_long_cmd(lcd_rs, lcd_data) ? CLEAR_LOAD : CMD_LOAD;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
`ifdef LCD_INIT_EN
            state <= (init_idx != 3'(INIT_ROM_LEN)) ? ST_INIT : ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end
        end
        default: begin
          lcd_e <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver: a scoreboard queue of accepted bytes is compared
// against every lcd_e rising edge, plus cycle-exact strobe, busy and FIFO checks.
module tb_lcd_driver;

  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int HOLD  = 2;
  localparam int CMDW  = 10;
  localparam int CLRW  = 50;
`ifdef LCD_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  lcd_if wr_bus ();

  lcd_driver #(
    .FIFO_DEPTH        (4),
    .SETUP_CYCLES      (SETUP),
    .PULSE_CYCLES      (PULSE),
    .HOLD_CYCLES       (HOLD),
    .CMD_WAIT_CYCLES   (CMDW),
    .CLEAR_WAIT_CYCLES (CLRW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr_bus),
    .busy       (busy),
    .fifo_count (fifo_count),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         ecnt = 0;
  int         strobes = 0;
  logic       e_prev = 1'b0;
  logic [8:0] sb_q[$];
  int         rise_q[$];

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Every strobe must carry the oldest outstanding accepted byte.
  always @(negedge clk) begin
    logic [31:0] exp_byte;
    if (lcd_e && !e_prev) begin
      strobes++;
      rise_q.push_back(ecnt);
      exp_byte = (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 32'hDEAD;
      check_output("strobe_byte", 32'({lcd_rs, lcd_data}), exp_byte);
    end
    e_prev = lcd_e;
  end

  task automatic apply_stimulus(input logic rs, input logic [7:0] data,
                                output int t, output logic acc);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_rs    = rs;
    wr_bus.wr_data  = data;
    acc = wr_bus.wr_ready;
    @(posedge clk);
    if (acc) sb_q.push_back({rs, data});
    @(negedge clk);
    wr_bus.wr_valid = 1'b0;
    t = ecnt;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(busy), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    if (INIT_EN) begin
      sb_q.push_back({1'b0, 8'h38});
      sb_q.push_back({1'b0, 8'h0C});
      sb_q.push_back({1'b0, 8'h01});
      sb_q.push_back({1'b0, 8'h06});
    end
  endtask

  task automatic period_case(input logic rs, input logic [7:0] data, input int wait_cyc,
                             input string tag);
    int   t, t2, first, second;
    logic a, a2;
    rise_q.delete();
    apply_stimulus(rs, data, t, a);
    apply_stimulus(1'b1, 8'h55, t2, a2);
    wait_idle(400, {tag, "_idle"});
    check_output({tag, "_strobes"}, 32'(rise_q.size()), 32'd2);
    first  = (rise_q.size() > 0) ? rise_q[0] : -1;
    second = (rise_q.size() > 1) ? rise_q[1] : -1;
    check_output({tag, "_first_rise"}, 32'(first), 32'(t + 1 + SETUP));
    check_output({tag, "_period"}, 32'(second - first), 32'(1 + SETUP + PULSE + HOLD + wait_cyc));
  endtask

  initial begin
    int   t, base, n;
    logic acc;
    int   exp_acc[6];
    int   exp_cnt[6];

    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_rs    = 1'b0;
    wr_bus.wr_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check_output("rst_lcd_data", 32'(lcd_data), 32'h00);
    check_output("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    check_output("rst_lcd_rw", 32'(lcd_rw), 32'd0);
    check_output("rst_lcd_e", 32'(lcd_e), 32'd0);
    check_output("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_output("rst_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'(INIT_EN));

    release_reset();

    if (INIT_EN) begin
      apply_stimulus(1'b1, 8'h5A, t, acc);
      check_output("init_push_acc", 32'(acc), 32'd1);
      check_output("init_busy", 32'(busy), 32'd1);
      wait_idle(1000, "init_idle");
      check_output("init_strobes", 32'(strobes), 32'd5);
      check_output("init_sb_empty", 32'(sb_q.size()), 32'd0);
    end

    // Single data byte: exact strobe window, busy release, and held bus values.
    $display("[TB] single byte timing");
    rise_q.delete();
    apply_stimulus(1'b1, 8'h41, t, acc);
    check_output("t1_acc", 32'(acc), 32'd1);
    check_output("t1_count_after_push", 32'(fifo_count), 32'd1);
    check_output("t1_busy_after_push", 32'(busy), 32'd1);
    @(negedge clk);
    check_output("t1_lcd_data", 32'(lcd_data), 32'h41);
    check_output("t1_lcd_rs", 32'(lcd_rs), 32'd1);
    check_output("t1_count_after_pop", 32'(fifo_count), 32'd0);
    check_output("t1_e_setup", 32'(lcd_e), 32'd0);
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      check_output($sformatf("t1_e_k%0d", k), 32'(lcd_e), 32'((k >= 3 && k <= 6) ? 1 : 0));
      check_output($sformatf("t1_busy_k%0d", k), 32'(busy), 32'((k <= 18) ? 1 : 0));
    end
    check_output("t1_data_held", 32'(lcd_data), 32'h41);
    check_output("t1_rs_held", 32'(lcd_rs), 32'd1);

    // Execution wait depends on clear/home commands only.
    $display("[TB] execution wait selection");
    period_case(1'b0, 8'h01, CLRW, "clear");
    period_case(1'b0, 8'h80, CMDW, "cmd80");
    period_case(1'b0, 8'h02, CLRW, "home");
    period_case(1'b1, 8'h01, CMDW, "data01");

    // Back-to-back pushes: first push is popped while the second lands, then the FIFO fills.
    $display("[TB] fifo fill");
    exp_acc = '{1, 1, 1, 1, 1, 0};
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    base = strobes;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 8'hA0 + 8'(i), t, acc);
      check_output($sformatf("fill_acc_%0d", i), 32'(acc), 32'(exp_acc[i]));
      check_output($sformatf("fill_count_%0d", i), 32'(fifo_count), 32'(exp_cnt[i]));
    end
    check_output("fill_wr_ready_full", 32'(wr_bus.wr_ready), 32'd0);
    wait_idle(1000, "fill_idle");
    check_output("fill_strobes", 32'(strobes - base), 32'd5);
    check_output("fill_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a strobe.
    $display("[TB] reset during pulse");
    apply_stimulus(1'b1, 8'h11, t, acc);
    apply_stimulus(1'b1, 8'h22, t, acc);
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("mid_reached_pulse", 32'(lcd_e), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_lcd_e", 32'(lcd_e), 32'd0);
    check_output("mid_rst_fifo_count", 32'(fifo_count), 32'd0);
    check_output("mid_rst_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
    check_output("mid_rst_lcd_data", 32'(lcd_data), 32'h00);
    sb_q.delete();
    base = strobes;
    repeat (2) @(negedge clk);
    release_reset();
    wait_idle(1000, "mid_idle");
    repeat (60) @(negedge clk);
    check_output("mid_strobes_after", 32'(strobes - base), 32'(INIT_EN ? 4 : 0));
    check_output("mid_sb_empty", 32'(sb_q.size()), 32'd0);
    check_output("mid_lcd_e_final", 32'(lcd_e), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
